div_repsub: RTL and testbench

//  Unsigned integer divider, the inverse of the team's repeated-addition multiplier.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_datapath.sv | 83 ++++++++
 rtl/div_repsub.sv | 134 +++++++++++++
 tb/tb_div_repsub.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the repeated-subtraction divider:
//   - W_DEF   : default operand width
//   - state_t : controller state encoding (3-bit)
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_SUB  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage : div_pkg

// File: rtl/div_datapath.sv
// -----------------------------------------------------------------------------
// div_datapath
// Register file and arithmetic for the repeated-subtraction divider.
//   A : running remainder (loaded with the dividend)
//   B : divisor
//   Q : quotient counter
// Ports:
//   clk, rst     in   clock, asynchronous active-high reset
//   i_data       in   W  shared operand bus
//   i_ldA        in   1  load A from i_data
//   i_ldB        in   1  load B from i_data
//   i_clrQ       in   1  clear Q
//   i_sub_en     in   1  A <= A - B, Q <= Q + 1
//   o_ge         out  1  A >= B (unsigned)
//   o_bz         out  1  divisor on the bus is zero
//   o_a          out  W  current A
//   o_q          out  W  current Q
// -----------------------------------------------------------------------------
module div_datapath
  import div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_data,
  input  logic         i_ldA,
  input  logic         i_ldB,
  input  logic         i_clrQ,
  input  logic         i_sub_en,
  output logic         o_ge,
  output logic         o_bz,
  output logic [W-1:0] o_a,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_q;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_q_inc;

  // The controller only asserts i_sub_en while A >= B, so this never wraps.
  assign w_diff  = r_a - r_b;
  assign w_q_inc = r_q + {{(W-1){1'b0}}, 1'b1};

  assign o_ge = (r_a >= r_b);
  // Zero detect looks at the bus rather than B: the decision to skip the
  // subtract loop is made in the same cycle B is being loaded.
  assign o_bz = (i_data == '0);

  assign o_a = r_a;
  assign o_q = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
    end else if (i_ldA) begin
      r_a <= i_data;
    end else if (i_sub_en) begin
      r_a <= w_diff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b <= '0;
    end else if (i_ldB) begin
      r_b <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clrQ) begin
      r_q <= '0;
    end else if (i_sub_en) begin
      r_q <= w_q_inc;
    end
  end

endmodule : div_datapath

// File: rtl/div_repsub.sv
// -----------------------------------------------------------------------------
// div_repsub
// Unsigned W-bit divider by repeated subtraction. Dividend then divisor are
// presented on data_in on the two cycles after start is accepted; the result
// is presented while done is high and held in S_IDLE until the next load.
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   start      in   1  request, sampled only in S_IDLE
//   data_in    in   W  dividend (S_LDA), divisor (S_LDB)
//   quotient   out  W  quotient; all ones on divide by zero
//   remainder  out  W  remainder; the dividend on divide by zero
//   done       out  1  high while in S_DONE
//   div_zero   out  1  divisor was zero
// -----------------------------------------------------------------------------
module div_repsub
  import div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done,
  output logic         div_zero
);

  state_t       r_state;
  state_t       w_next;
  logic         r_dz;

  logic         w_ldA;
  logic         w_ldB;
  logic         w_clrQ;
  logic         w_sub_en;
  logic         w_set_dz;
  logic         w_clr_dz;
  logic         w_ge;
  logic         w_bz;
  logic [W-1:0] w_a;
  logic [W-1:0] w_q;

  div_datapath #(
    .W (W)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .i_data   (data_in),
    .i_ldA    (w_ldA),
    .i_ldB    (w_ldB),
    .i_clrQ   (w_clrQ),
    .i_sub_en (w_sub_en),
    .o_ge     (w_ge),
    .o_bz     (w_bz),
    .o_a      (w_a),
    .o_q      (w_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dz <= 1'b0;
    end else if (w_clr_dz) begin
      r_dz <= 1'b0;
    end else if (w_set_dz) begin
      r_dz <= 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ldA    = 1'b0;
    w_ldB    = 1'b0;
    w_clrQ   = 1'b0;
    w_sub_en = 1'b0;
    w_set_dz = 1'b0;
    w_clr_dz = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_LDA;
        end
      end
      S_LDA: begin
        w_ldA    = 1'b1;
        w_clrQ   = 1'b1;
        w_clr_dz = 1'b1;
        w_next   = S_LDB;
      end
      S_LDB: begin
        w_ldB = 1'b1;
        if (w_bz) begin
          w_set_dz = 1'b1;
          w_next   = S_DONE;
        end else begin
          w_next = S_SUB;
        end
      end
      S_SUB: begin
        // One subtraction per cycle; the cycle that finds A < B only exits.
        if (w_ge) begin
          w_sub_en = 1'b1;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        // Holding start keeps us here so a held request cannot retrigger.
        if (!start) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign done      = (r_state == S_DONE);
  assign div_zero  = r_dz;
  assign quotient  = r_dz ? {W{1'b1}} : w_q;
  assign remainder = w_a;

endmodule : div_repsub

// File: tb/tb_div_repsub.sv
module tb_div_repsub;

  localparam int W = 16;
  localparam int LIMIT = 5000;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         done;
  logic         div_zero;

  int errors;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  div_repsub #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .div_zero  (div_zero)
  );

  // Reference: plain integer division, latency counted from the start edge.
  task automatic model(input int a, input int b, output logic [W-1:0] q,
                       output logic [W-1:0] r, output logic dz, output int lat);
    if (b == 0) begin
      q = {W{1'b1}}; r = a[W-1:0]; dz = 1'b1; lat = 2;
    end else begin
      q = W'(a / b); r = W'(a % b); dz = 1'b0; lat = a / b + 3;
    end
  endtask

  // Drives one operation; returns the edge index on which done was first seen.
  task automatic run_op(input int a, input int b, input bit hold,
                        output int lat, output bit to);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    data_in = a[W-1:0];
    @(posedge clk); #1;
    data_in = b[W-1:0];
    @(posedge clk); #1;
    lat = 2; to = 1'b0;
    while (done !== 1'b1 && !to) begin
      @(posedge clk); #1;
      lat++;
      if (lat > LIMIT) to = 1'b1;
    end
    data_in = $urandom();
  endtask

  task automatic test_reset();
    checks++;
    if (quotient !== '0 || remainder !== '0 || done !== 1'b0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: q=%0h r=%0h done=%b dz=%b required all 0",
               quotient, remainder, done, div_zero);
    end
  endtask

  task automatic test_directed();
    int a_t[4] = '{17, 1000, 4, 0};
    int b_t[4] = '{5, 1, 9, 7};
    logic [W-1:0] eq, er; logic edz; int elat, lat; bit to;
    for (int i = 0; i < 4; i++) begin
      model(a_t[i], b_t[i], eq, er, edz, elat);
      run_op(a_t[i], b_t[i], 1'b0, lat, to);
      checks++;
      if (to) begin
        errors++; $display("FAIL directed_timeout %0d/%0d: no done after %0d edges", a_t[i], b_t[i], lat);
      end
      checks++;
      if (quotient !== eq || remainder !== er || div_zero !== edz) begin
        errors++;
        $display("FAIL directed_result %0d/%0d: q=%0d r=%0d dz=%b required q=%0d r=%0d dz=%b",
                 a_t[i], b_t[i], quotient, remainder, div_zero, eq, er, edz);
      end
      checks++;
      if (lat !== elat) begin
        errors++; $display("FAIL directed_latency %0d/%0d: edge %0d required %0d", a_t[i], b_t[i], lat, elat);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat; bit to;
    run_op(42, 0, 1'b0, lat, to);
    checks++;
    if (to || lat !== 2) begin
      errors++; $display("FAIL divzero_latency: edge %0d timeout=%b required edge 2", lat, to);
    end
    checks++;
    if (quotient !== 16'hFFFF || remainder !== 16'd42 || div_zero !== 1'b1) begin
      errors++;
      $display("FAIL divzero_result: q=%0h r=%0d dz=%b required q=ffff r=42 dz=1",
               quotient, remainder, div_zero);
    end
  endtask

  task automatic test_random();
    int a, b, lat, elat; bit to;
    logic [W-1:0] eq, er; logic edz;
    for (int i = 0; i < 12; i++) begin
      a = int'($urandom_range(0, 65535));
      if (i % 4 == 3) b = 0;
      else begin
        b = int'($urandom_range(1, 65535));
        if (a / b > 200) b = a / 200 + 1;
      end
      model(a, b, eq, er, edz, elat);
      run_op(a, b, 1'b0, lat, to);
      checks++;
      if (to || quotient !== eq || remainder !== er || div_zero !== edz || lat !== elat) begin
        errors++;
        $display("FAIL random %0d/%0d: q=%0d r=%0d dz=%b edge=%0d required q=%0d r=%0d dz=%b edge=%0d",
                 a, b, quotient, remainder, div_zero, lat, eq, er, edz, elat);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit to;
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; data_in = 16'hFFFF;
    @(posedge clk); #1; data_in = 16'd1;
    repeat (12) @(posedge clk);
    #3; rst = 1'b1;
    #1;
    checks++;
    if (quotient !== '0 || remainder !== '0 || done !== 1'b0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: q=%0h r=%0h done=%b dz=%b required all 0",
               quotient, remainder, done, div_zero);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    run_op(20, 6, 1'b0, lat, to);
    checks++;
    if (to || quotient !== 16'd3 || remainder !== 16'd2 || lat !== 6) begin
      errors++;
      $display("FAIL reset_then_20_6: q=%0d r=%0d edge=%0d required q=3 r=2 edge=6",
               quotient, remainder, lat);
    end
  endtask

  task automatic test_hold_start();
    int lat; bit to;
    run_op(17, 5, 1'b1, lat, to);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || quotient !== 16'd3 || remainder !== 16'd2) begin
        errors++;
        $display("FAIL hold_done cycle %0d: done=%b q=%0d r=%0d required done=1 q=3 r=2",
                 i, done, quotient, remainder);
      end
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || quotient !== 16'd3 || remainder !== 16'd2) begin
      errors++;
      $display("FAIL idle_hold: done=%b q=%0d r=%0d required done=0 q=3 r=2",
               done, quotient, remainder);
    end
    run_op(100, 10, 1'b0, lat, to);
    checks++;
    if (to || quotient !== 16'd10 || remainder !== 16'd0 || div_zero !== 1'b0 || lat !== 13) begin
      errors++;
      $display("FAIL after_hold_100_10: q=%0d r=%0d dz=%b edge=%0d required q=10 r=0 dz=0 edge=13",
               quotient, remainder, div_zero, lat);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    start = 1'b0;
    data_in = '0;
    @(posedge clk); #2;
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_directed();
    test_div_zero();
    test_random();
    test_reset_mid();
    test_hold_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_div_repsub
